// File: rtl/quad_encoder_pkg.sv
// Shared types and transition tables for the quadrature decoder.
package quad_encoder_pkg;

  typedef logic [1:0] enc_state_t;

  typedef enum logic [1:0] {STEP_NONE, STEP_INC, STEP_DEC, STEP_ERR} step_t;

  localparam enc_state_t ST_IDLE = 2'b00;

  // Bit {prev,cur} is set when prev->cur is a legal forward (00->10->11->01->00)
  // or reverse transition.
  localparam logic [15:0] FWD_MASK = 16'h2814;
  localparam logic [15:0] REV_MASK = 16'h4182;

  localparam int ERR_CNT_MAX = 255;

  function automatic step_t classify(enc_state_t prev, enc_state_t cur);
    if (cur == prev)                 return STEP_NONE;
    else if (FWD_MASK[{prev, cur}])  return STEP_INC;
    else if (REV_MASK[{prev, cur}])  return STEP_DEC;
    else                             return STEP_ERR;
  endfunction

endpackage

// File: rtl/enc_input_filter.sv
// One encoder pin: SYNC_STAGES-deep synchroniser followed by a debounce counter
// that accepts a new level after filt_len+1 consecutive differing cycles.
module enc_input_filter #(
  parameter int FILT_WIDTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  gclk,
  input  logic                  grst_n,
  input  logic                  pin,
  input  logic [FILT_WIDTH-1:0] filt_len,
  output logic                  level
);

  logic [SYNC_STAGES-1:0] sync_pipe;
  logic [FILT_WIDTH-1:0]  stab_cnt;
  logic                   sync_lvl;

  assign sync_lvl = sync_pipe[SYNC_STAGES-1];

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      sync_pipe <= '0;
      stab_cnt  <= '0;
      level     <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], pin};
      if (sync_lvl == level) begin
        stab_cnt <= '0;
      end else if (stab_cnt >= filt_len) begin
        // >= so a shortened filt_len mid-count still terminates
        level    <= sync_lvl;
        stab_cnt <= '0;
      end else begin
        stab_cnt <= stab_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/quad_encoder_core.sv
// x4 quadrature decoder: filtered A/B/Z, signed position, windowed velocity, error flags.
// Optional macro QUAD_ENCODER_INDEX_CLEAR_EN: Z rising edge at AB=00 zeroes position.
module quad_encoder_core
  import quad_encoder_pkg::*;
#(
  parameter int CNT_WIDTH   = 32,
  parameter int FILT_WIDTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  enc_a,
  input  logic                  enc_b,
  input  logic                  enc_z,
  input  logic                  cfg_enable,
  input  logic                  cfg_invert,
  input  logic [FILT_WIDTH-1:0] cfg_filt_len,
  input  logic [CNT_WIDTH-1:0]  cfg_vel_window,
  input  logic                  pos_clear,
  input  logic                  err_clear,
  output logic [CNT_WIDTH-1:0]  position,
  output logic [CNT_WIDTH-1:0]  velocity,
  output logic                  vel_valid,
  output logic                  direction,
  output logic                  err_sticky,
  output logic [7:0]            err_count,
  output logic                  index_seen
);

  localparam int NUM_PINS = 3;

  // pin vector: [0]=B, [1]=A, [2]=Z so that [1:0] is the {A,B} state
  logic [NUM_PINS-1:0] pin_raw, pin_filt;
  assign pin_raw = {enc_z, enc_a, enc_b};

  for (genvar p = 0; p < NUM_PINS; p++) begin : g_pin
    enc_input_filter #(
      .FILT_WIDTH (FILT_WIDTH),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_filt (
      .gclk    (ACLK),
      .grst_n  (ARESETN),
      .pin     (pin_raw[p]),
      .filt_len(cfg_filt_len),
      .level   (pin_filt[p])
    );
  end

  enc_state_t cur_ab, prev_ab;
  step_t      step_kind;
  logic       step_vld, inc_pos, pos_zero, index_evt;
  logic [CNT_WIDTH-1:0] step_val, pos_q, vel_acc, win_cnt;
  logic       win_last;

  assign cur_ab    = pin_filt[1:0];
  assign step_kind = cfg_enable ? classify(prev_ab, cur_ab) : STEP_NONE;
  assign step_vld  = (step_kind == STEP_INC) || (step_kind == STEP_DEC);
  assign inc_pos   = (step_kind == STEP_INC) ^ cfg_invert;
  assign step_val  = !step_vld ? '0 :
                     inc_pos   ? {{(CNT_WIDTH-1){1'b0}}, 1'b1} : '1;

`ifdef QUAD_ENCODER_INDEX_CLEAR_EN
  logic z_prev;
  assign index_evt = pin_filt[2] && !z_prev && (cur_ab == ST_IDLE);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      z_prev     <= 1'b0;
      index_seen <= 1'b0;
    end else begin
      z_prev <= pin_filt[2];
      if (index_evt) index_seen <= 1'b1;
    end
  end
`else
  logic unused_z;
  assign unused_z   = pin_filt[2];
  assign index_evt  = 1'b0;
  assign index_seen = 1'b0;
`endif

  assign pos_zero = pos_clear || index_evt;
  assign position = pos_q;

  // prev_ab tracks even while disabled so re-enabling never sees a stale edge
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      prev_ab   <= ST_IDLE;
      pos_q     <= '0;
      direction <= 1'b0;
    end else begin
      prev_ab <= cur_ab;
      if (pos_zero) begin
        pos_q <= '0;
      end else if (step_vld) begin
        pos_q     <= pos_q + step_val;
        direction <= inc_pos;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      err_sticky <= 1'b0;
      err_count  <= '0;
    end else if (err_clear) begin
      err_sticky <= 1'b0;
      err_count  <= '0;
    end else if (step_kind == STEP_ERR) begin
      err_sticky <= 1'b1;
      if (err_count != 8'(ERR_CNT_MAX)) err_count <= err_count + 1'b1;
    end
  end

  // >= lets a shrunken window terminate on the next cycle
  assign win_last = (cfg_vel_window != '0) && (win_cnt >= cfg_vel_window - 1'b1);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      win_cnt   <= '0;
      vel_acc   <= '0;
      velocity  <= '0;
      vel_valid <= 1'b0;
    end else begin
      vel_valid <= 1'b0;
      if (cfg_vel_window == '0) begin
        win_cnt <= '0;
        vel_acc <= '0;
      end else if (cfg_enable) begin
        if (win_last) begin
          velocity  <= vel_acc + step_val;
          vel_acc   <= '0;
          win_cnt   <= '0;
          vel_valid <= 1'b1;
        end else begin
          vel_acc <= vel_acc + step_val;
          win_cnt <= win_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_quad_encoder_core.sv
// Self-checking bench for quad_encoder_core: vector table, hand-written corner
// sequences and a randomized run against a phase-arithmetic reference model.
module tb_quad_encoder_core;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        enc_a, enc_b, enc_z;
  logic        cfg_enable, cfg_invert;
  logic [3:0]  cfg_filt_len;
  logic [31:0] cfg_vel_window;
  logic        pos_clear, err_clear;
  logic [31:0] position, velocity;
  logic        vel_valid, direction, err_sticky, index_seen;
  logic [7:0]  err_count;

  quad_encoder_core dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .enc_a(enc_a), .enc_b(enc_b), .enc_z(enc_z),
    .cfg_enable(cfg_enable), .cfg_invert(cfg_invert), .cfg_filt_len(cfg_filt_len),
    .cfg_vel_window(cfg_vel_window), .pos_clear(pos_clear), .err_clear(err_clear),
    .position(position), .velocity(velocity), .vel_valid(vel_valid),
    .direction(direction), .err_sticky(err_sticky), .err_count(err_count),
    .index_seen(index_seen)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [1:0]  m_ab;
  logic [31:0] m_pos;
  logic        m_dir, m_sticky;
  int          m_errs;

  typedef struct {
    logic [1:0]  ab;
    logic        inv;
    logic [31:0] pos;
    logic        dir;
    int          errs;
  } vec_t;
  vec_t tbl[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge ACLK);
  endtask

  // Gray-code phase: one quarter turn forward per legal step
  function automatic int phase(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_apply(input logic [1:0] ab);
    int d;
    logic up;
    d = (phase(ab) - phase(m_ab) + 4) % 4;
    if (d == 1 || d == 3) begin
      up = (d == 1) ^ cfg_invert;
      m_pos = up ? m_pos + 32'd1 : m_pos - 32'd1;
      m_dir = up;
    end else if (d == 2) begin
      if (m_errs < 255) m_errs++;
      m_sticky = 1'b1;
    end
    m_ab = ab;
  endtask

  // drive a new AB state at a negedge, check the 4-cycle latency, then idle
  task automatic step_to(input logic [1:0] ab, input int idle);
    logic [31:0] old_pos;
    old_pos = m_pos;
    {enc_a, enc_b} = ab;
    model_apply(ab);
    cyc(3);
    check("lat_before", position, old_pos);
    cyc(1);
    check("step_pos", position, m_pos);
    cyc(idle);
  endtask

  initial begin
    ARESETN = 1'b0;
    {enc_a, enc_b, enc_z} = 3'b000;
    cfg_enable = 1'b1; cfg_invert = 1'b0; cfg_filt_len = 4'd0; cfg_vel_window = 32'd0;
    pos_clear = 1'b0; err_clear = 1'b0;
    m_ab = 2'b00; m_pos = 0; m_dir = 0; m_sticky = 0; m_errs = 0;

    tbl[0]  = '{2'b10, 1'b0, 32'd1,  1'b1, 0};
    tbl[1]  = '{2'b11, 1'b0, 32'd2,  1'b1, 0};
    tbl[2]  = '{2'b01, 1'b0, 32'd3,  1'b1, 0};
    tbl[3]  = '{2'b00, 1'b0, 32'd4,  1'b1, 0};
    tbl[4]  = '{2'b10, 1'b0, 32'd5,  1'b1, 0};
    tbl[5]  = '{2'b11, 1'b0, 32'd6,  1'b1, 0};
    tbl[6]  = '{2'b01, 1'b0, 32'd7,  1'b1, 0};
    tbl[7]  = '{2'b00, 1'b0, 32'd8,  1'b1, 0};
    tbl[8]  = '{2'b01, 1'b1, 32'd9,  1'b1, 0};
    tbl[9]  = '{2'b11, 1'b1, 32'd10, 1'b1, 0};
    tbl[10] = '{2'b10, 1'b1, 32'd11, 1'b1, 0};
    tbl[11] = '{2'b01, 1'b1, 32'd11, 1'b1, 1};
    tbl[12] = '{2'b00, 1'b1, 32'd10, 1'b0, 1};
    tbl[13] = '{2'b11, 1'b1, 32'd10, 1'b0, 2};

    // reset state
    cyc(3);
    check("rst_position", position, 0);
    check("rst_velocity", velocity, 0);
    check("rst_vel_valid", 32'(vel_valid), 0);
    check("rst_direction", 32'(direction), 0);
    check("rst_err_sticky", 32'(err_sticky), 0);
    check("rst_err_count", 32'(err_count), 0);
    check("rst_index_seen", 32'(index_seen), 0);
    ARESETN = 1'b1;
    cyc(3);

    // vector table: 8 forward, 3 inverted reverse, illegal jumps
    for (int i = 0; i < 14; i++) begin
      logic [31:0] prev_pos;
      prev_pos = (i == 0) ? 32'd0 : tbl[i-1].pos;
      cfg_invert = tbl[i].inv;
      {enc_a, enc_b} = tbl[i].ab;
      cyc(3);
      check("tbl_latency", position, prev_pos);
      cyc(1);
      check("tbl_pos", position, tbl[i].pos);
      check("tbl_dir", 32'(direction), 32'(tbl[i].dir));
      check("tbl_errs", 32'(err_count), 32'(tbl[i].errs));
      check("tbl_sticky", 32'(err_sticky), 32'(tbl[i].errs != 0));
      cyc(6);
    end
    m_ab = 2'b11; m_pos = 10; m_dir = 0; m_errs = 2; m_sticky = 1;
    cfg_invert = 1'b0;

    err_clear = 1'b1; cyc(1); err_clear = 1'b0;
    check("errclr_sticky", 32'(err_sticky), 0);
    check("errclr_count", 32'(err_count), 0);
    m_errs = 0; m_sticky = 0;

    // err_clear in the same cycle as an illegal transition: clear wins
    {enc_a, enc_b} = 2'b00;
    cyc(3); err_clear = 1'b1; cyc(1); err_clear = 1'b0;
    check("errclr_coinc_count", 32'(err_count), 0);
    check("errclr_coinc_sticky", 32'(err_sticky), 0);
    check("errclr_coinc_pos", position, 10);
    m_ab = 2'b00;
    cyc(5);

    // debounce N=3: 2-cycle glitch rejected, held level accepted after 2+4+1
    cfg_filt_len = 4'd3; cyc(2);
    enc_a = 1'b1; cyc(2); enc_a = 1'b0; cyc(12);
    check("glitch_reject", position, 10);
    enc_a = 1'b1;
    cyc(6);
    check("debounce_before", position, 10);
    cyc(1);
    check("debounce_step", position, 11);
    cyc(10);
    check("debounce_once", position, 11);
    m_ab = 2'b10; m_pos = 11; m_dir = 1;
    cfg_filt_len = 4'd0; cyc(2);

    // velocity windows of 100: +5 then -2
    begin
      int pulses;
      logic [1:0] seq[7];
      int at[7];
      pulses = 0;
      seq = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b11, 2'b10, 2'b00};
      at  = '{1, 11, 21, 31, 41, 111, 121};
      cfg_vel_window = 32'd100;
      for (int i = 1; i <= 200; i++) begin
        for (int k = 0; k < 7; k++)
          if (at[k] == i) begin
            {enc_a, enc_b} = seq[k];
            model_apply(seq[k]);
          end
        cyc(1);
        if (vel_valid) pulses++;
        if (i == 100) begin
          check("vel_valid_w1", 32'(vel_valid), 1);
          check("velocity_w1", velocity, 32'd5);
        end
        if (i == 200) begin
          check("vel_valid_w2", 32'(vel_valid), 1);
          check("velocity_w2", velocity, 32'hFFFF_FFFE);
        end
      end
      check("vel_pulse_count", pulses, 2);
      check("vel_run_pos", position, m_pos);
      cfg_vel_window = 32'd0;
      pulses = 0;
      for (int i = 0; i < 30; i++) begin
        cyc(1);
        if (vel_valid) pulses++;
      end
      check("vel_w0_no_pulse", pulses, 0);
      check("vel_w0_hold", velocity, 32'hFFFF_FFFE);
    end

    // wrap: 0x7FFFFFFF + 1
    force dut.pos_q = 32'h7FFF_FFFF;
    cyc(1);
    release dut.pos_q;
    m_pos = 32'h7FFF_FFFF;
    cyc(1);
    check("force_hold", position, 32'h7FFF_FFFF);
    step_to(2'b10, 6);
    check("wrap_pos", position, 32'h8000_0000);

    // pos_clear coincident with a step: clear wins
    {enc_a, enc_b} = 2'b11;
    cyc(3); pos_clear = 1'b1; cyc(1); pos_clear = 1'b0;
    check("clr_coinc", position, 0);
    cyc(5);
    check("clr_coinc_hold", position, 0);
    m_ab = 2'b11; m_pos = 0;
    step_to(2'b10, 6);
    check("wrap_neg", position, 32'hFFFF_FFFF);
    step_to(2'b11, 6);

    // disabled: prev state follows pins, no false step on enable
    cfg_enable = 1'b0;
    {enc_a, enc_b} = 2'b01; m_ab = 2'b01;
    cyc(8);
    check("disabled_hold", position, m_pos);
    cfg_enable = 1'b1;
    cyc(8);
    check("enable_no_step", position, m_pos);
    step_to(2'b00, 6);

    // index channel
`ifdef QUAD_ENCODER_INDEX_CLEAR_EN
    for (int i = 0; i < 9; i++) begin
      step_to(2'b10, 2); step_to(2'b11, 2); step_to(2'b01, 2); step_to(2'b00, 2);
    end
    enc_z = 1'b1;
    cyc(3);
    check("idx_before", position, m_pos);
    cyc(1);
    check("idx_clear", position, 0);
    check("idx_seen", 32'(index_seen), 1);
    m_pos = 0;
    enc_z = 1'b0; cyc(6);
    step_to(2'b10, 4); step_to(2'b11, 4);
    enc_z = 1'b1; cyc(8);
    check("idx_ab11_ignored", position, m_pos);
    enc_z = 1'b0; cyc(6);
`else
    enc_z = 1'b1; cyc(8);
    check("idx_disabled_seen", 32'(index_seen), 0);
    check("idx_disabled_pos", position, m_pos);
    enc_z = 1'b0; cyc(6);
`endif

    // randomized transitions against the phase model
    for (int it = 0; it < 60; it++) begin
      logic [1:0] ab;
      int n;
      n = $urandom_range(0, 3);
      cfg_filt_len = 4'(n);
      cfg_invert = 1'($urandom_range(0, 1));
      ab = 2'($urandom_range(0, 3));
      cyc(1);
      {enc_a, enc_b} = ab;
      model_apply(ab);
      cyc(n + 4 + $urandom_range(0, 4));
      check("rnd_pos", position, m_pos);
      check("rnd_dir", 32'(direction), 32'(m_dir));
      check("rnd_errs", 32'(err_count), 32'(m_errs));
      check("rnd_sticky", 32'(err_sticky), 32'(m_sticky));
      if ($urandom_range(0, 7) == 0) begin
        err_clear = 1'b1; cyc(1); err_clear = 1'b0;
        m_errs = 0; m_sticky = 0;
      end
    end

    // async reset mid-operation; decode resumes from 00
    cfg_filt_len = 4'd0; cfg_invert = 1'b0;
    {enc_a, enc_b} = 2'b00; cyc(6);
    @(negedge ACLK);
    #2 ARESETN = 1'b0;
    #1;
    check("arst_position", position, 0);
    check("arst_err_count", 32'(err_count), 0);
    check("arst_velocity", velocity, 0);
    {enc_a, enc_b} = 2'b10;
    cyc(2);
    ARESETN = 1'b1;
    cyc(3);
    check("arst_resume_before", position, 0);
    cyc(1);
    check("arst_resume_step", position, 1);
    check("arst_resume_dir", 32'(direction), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
